fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Producer side of the instruction fetch buffer interface.
- Owns the fetch PC and issues aligned 64-bit fetch requests to instruction memory.
- Tracks in-flight requests, turns memory responses into two-slot instruction packets and throttles against the IFB full/afull back-pressure.
- Sits in the IFU between instruction memory and the fetch buffer; the IFU top packs its packet outputs into inst_pkt_t.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be zero.
- MAX_OUTST, 2, maximum in-flight memory requests; legal values are 1 and 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  flush/redirect from the branch unit; the same cycle drives the IFB flush
- redirect_pc  in  32  new fetch PC; bits [1:0] are zero
- ifb_full  in  1  IFB full
- ifb_afull  in  1  IFB holds at least one packet
- imem_req  out  1  request valid
- imem_addr  out  32  8-byte-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in order with latency of 1 or more cycles
- imem_rdata  in  64  [31:0] = instruction at addr, [63:32] = instruction at addr+4
- pkt_i0_valid  out  1  slot 0 valid
- pkt_i1_valid  out  1  slot 1 valid
- pkt_i0_inst  out  32  slot 0 instruction
- pkt_i1_inst  out  32  slot 1 instruction
- pkt_pc  out  32  PC of the first valid slot

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC; outst_cnt = 0; drop_cnt = 0; PC FIFO empty.
  - imem_req = 0; pkt_i0_valid and pkt_i1_valid = 0; all data outputs 0.
- Occupancy: occ = 2 if ifb_full, else 1 if ifb_afull, else 0.
- Credit rule: imem_req = !redirect_valid && outst_cnt < MAX_OUTST && (occ + outst_cnt) < 2.
  - The rule is conservative: IFB pops in the current cycle are ignored. This guarantees the IFB never receives a push while full.
- Request:
  - imem_addr = {pc[31:3], 3'b000}.
  - imem_req is combinational, and the address is held stable while the request is not granted.
  - Handshake = imem_req && imem_gnt. On handshake: push pc into the PC FIFO (depth MAX_OUTST); pc <= {pc[31:3]+1, 3'b000}. This wraps 32'hFFFF_FFF8 -> 0, and the carry beyond bit 31 is discarded.
- outst_cnt:
  - Increments on handshake and decrements on imem_rvalid; both in the same cycle leaves it unchanged.
  - imem_rvalid with outst_cnt = 0 is illegal and covered by an assertion.
- Response:
  - On imem_rvalid, pop the FIFO head as rpc.
  - If drop_cnt = 0 and !redirect_valid, the packet is produced combinationally in the same cycle:
    - pkt_i0_valid = !rpc[2]; pkt_i1_valid = 1.
    - pkt_i0_inst = rdata[31:0]; pkt_i1_inst = rdata[63:32].
    - pkt_pc = rpc.
  - Otherwise both valids are 0, and drop_cnt decrements if it is nonzero.
- Redirect, highest priority:
  - pc <= redirect_pc; no request in that cycle; PC FIFO cleared.
  - drop_cnt <= outst_cnt - (imem_rvalid ? 1 : 0). All in-flight responses are discarded; outst_cnt keeps counting them down.
  - Any response in the redirect cycle is suppressed.
  - A request is issued from redirect_pc in the next cycle if credit allows.
- Redirect while drop_cnt != 0: the new drop_cnt is recomputed by the same formula; drops do not accumulate.
- Redirect to a PC with bit 2 set: the first packet has i0_valid = 0 and pkt_pc = redirect_pc.
- Packet outputs are driven only in the response cycle; valids are 0 in every other cycle.
- Assertions:
  - drop_cnt <= outst_cnt <= MAX_OUTST.
  - imem_addr[2:0] = 0.

Test Plan:
- Reset with RESET_PC = 0, zero-latency-1 memory always granting, IFB empty -> addresses 0x0 and 0x8 issued on consecutive cycles; then stall (occ + outst = 2) until the IFB drains. Packets carry pc = 0x0 then 0x8, both slots valid.
- redirect_pc = 0x104 -> next request address 0x100; the packet has i0_valid = 0, i1_valid = 1, pkt_pc = 0x104, i1_inst = rdata[63:32].
- Two requests in flight with latency 3, redirect to 0x200 one cycle after the second grant -> the two returning responses produce no packets. The first packet is from 0x200; drop_cnt returns to 0.
- Redirect in the same cycle as imem_rvalid with outst = 2 -> the response is suppressed, drop_cnt = 1, and the next response is dropped.
- ifb_full held 10 cycles with outst = 0 -> imem_req stays 0. Release full with afull = 1 -> exactly one request is issued.
- pc = 0xFFFF_FFF8 granted -> next imem_addr = 0x0000_0000. Assert rst_n low mid-flight -> outputs clear immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues aligned 64-bit instruction memory
// requests under IFB credit, and turns in-order responses into two-slot packets.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ifb_full,
  input  logic        ifb_afull,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output logic        pkt_i0_valid,
  output logic        pkt_i1_valid,
  output logic [31:0] pkt_i0_inst,
  output logic [31:0] pkt_i1_inst,
  output logic [31:0] pkt_pc
);

  localparam logic [1:0] MaxOutst = 2'(MAX_OUTST);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] fifo_q [2];
  logic [31:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;

  logic [1:0]  occ;
  logic [2:0]  credit_sum;
  logic        hs;
  logic        pkt_fire;
  logic [31:0] rpc;

  // Credit check: pops in the current cycle are ignored so the IFB is never pushed while full.
  always_comb begin
    occ        = ifb_full ? 2'd2 : (ifb_afull ? 2'd1 : 2'd0);
    credit_sum = {1'b0, occ} + {1'b0, outst_q};
    imem_req   = rst_n && !redirect_valid && (outst_q < MaxOutst) && (credit_sum < 3'd2);
    imem_addr  = {pc_q[31:3], 3'b000};
    hs         = imem_req && imem_gnt;
  end

  // Response path: a packet is produced only for live (non-dropped) responses.
  always_comb begin
    rpc          = fifo_q[rd_ptr_q];
    pkt_fire     = rst_n && imem_rvalid && (drop_q == 2'd0) && !redirect_valid;
    pkt_i0_valid = pkt_fire && !rpc[2];
    pkt_i1_valid = pkt_fire;
    pkt_i0_inst  = pkt_fire ? imem_rdata[31:0]  : 32'h0;
    pkt_i1_inst  = pkt_fire ? imem_rdata[63:32] : 32'h0;
    pkt_pc       = pkt_fire ? rpc               : 32'h0;
  end

  // Next-state for PC, PC FIFO, in-flight and drop counters; redirect has priority.
  always_comb begin
    pc_d     = pc_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;

    // In-flight count tracks every response, including ones being dropped.
    unique case ({hs, imem_rvalid})
      2'b10:   outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: outst_d = outst_q;
    endcase

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      // Recomputed rather than accumulated: everything still in flight is stale.
      drop_d   = outst_q - {1'b0, imem_rvalid};
    end else begin
      if (hs) begin
        fifo_d[wr_ptr_q] = pc_q;
        wr_ptr_d         = ~wr_ptr_q;
        pc_d             = {pc_q[31:3] + 29'd1, 3'b000};
      end
      // Dropped responses never had a FIFO entry (the FIFO was cleared on redirect).
      if (pkt_fire) begin
        rd_ptr_d = ~rd_ptr_q;
      end else if (imem_rvalid && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      outst_q   <= 2'd0;
      drop_q    <= 2'd0;
      fifo_q[0] <= 32'h0;
      fifo_q[1] <= 32'h0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  a_cnt_order: assert property (@(posedge clk) disable iff (!rst_n)
    (drop_q <= outst_q) && (outst_q <= MaxOutst));
  a_addr_align: assert property (@(posedge clk) disable iff (!rst_n)
    imem_addr[2:0] == 3'b000);
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outst_q != 2'd0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: in-order memory model with programmable latency,
// hand-driven IFB back-pressure, and per-scenario cycle-exact checks.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ifb_full = 1'b0;
  logic        ifb_afull = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        pkt_i0_valid;
  logic        pkt_i1_valid;
  logic [31:0] pkt_i0_inst;
  logic [31:0] pkt_i1_inst;
  logic [31:0] pkt_pc;

  int n_checks = 0;
  int n_pass = 0;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MAX_OUTST(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ifb_full      (ifb_full),
    .ifb_afull     (ifb_afull),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pkt_i0_valid  (pkt_i0_valid),
    .pkt_i1_valid  (pkt_i1_valid),
    .pkt_i0_inst   (pkt_i0_inst),
    .pkt_i1_inst   (pkt_i1_inst),
    .pkt_pc        (pkt_pc)
  );

  always #5 clk = ~clk;

  // Memory model: always grants, returns responses in order after mem_lat cycles.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'h0;

  assign imem_gnt    = 1'b1;
  assign imem_rvalid = mem_rvalid & rst_n;
  assign imem_rdata  = mem_rdata;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) mq.delete();
    else if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: cyc + mem_lat});
    cyc++;
    #1;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = {inst_of(mq[0].addr + 32'd4), inst_of(mq[0].addr)};
      void'(mq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 64'h0;
    end
  end

  // Packet and handshake log, sampled mid-cycle.
  typedef logic [97:0] pkt_t;  // {i0_valid, i1_valid, i0_inst, i1_inst, pc}
  pkt_t plog[$];
  int   hs_total = 0;

  always @(negedge clk) begin
    if (pkt_i0_valid || pkt_i1_valid)
      plog.push_back({pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc});
    if (imem_req && imem_gnt) hs_total++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic quiesce();
    ifb_full       = 1'b1;
    ifb_afull      = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [130:0] got;
    mid();
    got = {imem_req, imem_addr, pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc};
    n_checks++;
    if (got !== 131'h0) $display("FAIL reset_outputs: got %h required 0", got);
    else n_pass++;
  endtask

  task automatic test_basic();
    tick(); rst_n = 1'b1;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL basic_req0: got %b/%h required 1/0", imem_req, imem_addr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) $display("FAIL basic_req1: got %b/%h required 1/8", imem_req, imem_addr);
    else n_pass++;
    n_checks++;
    if ({pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc} !== {2'b11, 32'hC0DE0000, 32'hC0DE0004, 32'h0})
      $display("FAIL basic_pkt0: got %b%b %h %h %h", pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc);
    else n_pass++;
    tick(); ifb_afull = 1'b1;
    mid();
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL basic_stall_occ: got req %b required 0", imem_req);
    else n_pass++;
    n_checks++;
    if ({pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc} !== {2'b11, 32'hC0DE0008, 32'hC0DE000C, 32'h8})
      $display("FAIL basic_pkt1: got %b%b %h %h %h", pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    mid();
    n_checks++;
    if ({imem_req, pkt_i0_valid, pkt_i1_valid} !== 3'b000) $display("FAIL basic_full_idle: got %b required 000", {imem_req, pkt_i0_valid, pkt_i1_valid});
    else n_pass++;
    repeat (3) tick();
    ifb_full = 1'b0; ifb_afull = 1'b0;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL basic_drain_req: got %b/%h required 1/10", imem_req, imem_addr);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    quiesce();
  endtask

  task automatic test_redirect_odd();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h104; ifb_full = 1'b0;
    mid();
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL odd_redirect_noreq: got %b required 0", imem_req);
    else n_pass++;
    tick(); redirect_valid = 1'b0;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) $display("FAIL odd_req_addr: got %b/%h required 1/100", imem_req, imem_addr);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    mid();
    n_checks++;
    if ({pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc} !== {2'b01, 32'hC0DE0100, 32'hC0DE0104, 32'h104})
      $display("FAIL odd_pkt: got %b%b %h %h %h required 01 c0de0100 c0de0104 104", pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_redirect_drop();
    int base;
    mem_lat = 3;
    base = plog.size();
    tick(); ifb_full = 1'b0;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h108}) $display("FAIL drop_req0: got %b/%h required 1/108", imem_req, imem_addr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h110}) $display("FAIL drop_req1: got %b/%h required 1/110", imem_req, imem_addr);
    else n_pass++;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(); redirect_valid = 1'b0;
    mid();
    n_checks++;
    if ({imem_rvalid, pkt_i0_valid, pkt_i1_valid, imem_req} !== 4'b1000) $display("FAIL drop_rsp0: got %b required 1000", {imem_rvalid, pkt_i0_valid, pkt_i1_valid, imem_req});
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({imem_rvalid, pkt_i0_valid, pkt_i1_valid} !== 3'b100) $display("FAIL drop_rsp1: got %b required 100", {imem_rvalid, pkt_i0_valid, pkt_i1_valid});
    else n_pass++;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h200}) $display("FAIL drop_new_req: got %b/%h required 1/200", imem_req, imem_addr);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (plog.size() - base !== 1 || plog[base] !== {2'b11, 32'hC0DE0200, 32'hC0DE0204, 32'h200})
      $display("FAIL drop_first_pkt: got %0d pkts first %h required 1 pkt pc 200", plog.size() - base, plog[base]);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_redirect_rvalid();
    int base;
    mem_lat = 2;
    base = plog.size();
    tick(); ifb_full = 1'b0;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h208}) $display("FAIL rvr_req0: got %b/%h required 1/208", imem_req, imem_addr);
    else n_pass++;
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h300;
    mid();
    n_checks++;
    if ({imem_rvalid, pkt_i0_valid, pkt_i1_valid} !== 3'b100) $display("FAIL rvr_suppress: got %b required 100", {imem_rvalid, pkt_i0_valid, pkt_i1_valid});
    else n_pass++;
    tick(); redirect_valid = 1'b0;
    mid();
    n_checks++;
    if ({imem_rvalid, pkt_i0_valid, pkt_i1_valid, imem_req, imem_addr} !== {4'b1001, 32'h300})
      $display("FAIL rvr_drop_next: got %b %h required 1001 300", {imem_rvalid, pkt_i0_valid, pkt_i1_valid, imem_req}, imem_addr);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (plog.size() - base !== 1 || plog[base] !== {2'b11, 32'hC0DE0300, 32'hC0DE0304, 32'h300})
      $display("FAIL rvr_pkt: got %0d pkts first %h required 1 pkt pc 300", plog.size() - base, plog[base]);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_full_stall();
    int h0;
    int req_cycles = 0;
    mem_lat = 1;
    h0 = hs_total;
    for (int i = 0; i < 10; i++) begin
      tick(); mid();
      if (imem_req) req_cycles++;
    end
    n_checks++;
    if (req_cycles !== 0) $display("FAIL full_hold: got %0d request cycles required 0", req_cycles);
    else n_pass++;
    tick(); ifb_full = 1'b0; ifb_afull = 1'b1;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h308}) $display("FAIL afull_req: got %b/%h required 1/308", imem_req, imem_addr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({imem_req, pkt_i1_valid, pkt_pc} !== {2'b01, 32'h308}) $display("FAIL afull_stall_pkt: got %b %b %h required 0 1 308", imem_req, pkt_i1_valid, pkt_pc);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (hs_total - h0 !== 1) $display("FAIL afull_one_req: got %0d requests required 1", hs_total - h0);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_wrap_reset();
    logic [130:0] got;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; ifb_full = 1'b0;
    tick(); redirect_valid = 1'b0;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFF8}) $display("FAIL wrap_req_top: got %b/%h required 1/fffffff8", imem_req, imem_addr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_req_zero: got %b/%h required 1/0", imem_req, imem_addr);
    else n_pass++;
    n_checks++;
    if ({pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc} !== {2'b11, 32'hC0DEFFF8, 32'hC0DEFFFC, 32'hFFFF_FFF8})
      $display("FAIL wrap_pkt: got %b%b %h %h %h", pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    got = {imem_req, imem_addr, pkt_i0_valid, pkt_i1_valid, pkt_i0_inst, pkt_i1_inst, pkt_pc};
    n_checks++;
    if (got !== 131'h0) $display("FAIL async_reset_clear: got %h required 0", got);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    mid();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL restart_req0: got %b/%h required 1/0", imem_req, imem_addr);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({imem_req, imem_addr, pkt_i1_valid, pkt_pc} !== {1'b1, 32'h8, 1'b1, 32'h0})
      $display("FAIL restart_req1_pkt: got %b/%h %b %h required 1/8 1 0", imem_req, imem_addr, pkt_i1_valid, pkt_pc);
    else n_pass++;
    tick(); ifb_full = 1'b1;
    quiesce();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_odd();
    test_redirect_drop();
    test_redirect_rvalid();
    test_full_stall();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
